// File: rtl/ps2_host_tx_if.sv
// CPU-side bus for the PS/2 host transmitter: registered DEVICE/DATA strobe in, status word out.
// Handshake: a transmit is requested by DEVICE becoming CMD_DEV (edge, not level) and is accepted
// only while status[0] (busy) is low; completion is reported by busy falling, with done/err valid one cycle later.
interface ps2_host_tx_if;
  logic [15:0] DEVICE;
  logic [15:0] DATA;
  logic [15:0] status;

  modport master (output DEVICE, output DATA, input status);
  modport slave  (input DEVICE, input DATA, output status);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB-first, odd parity, stop, ack.
// Optional watchdog on the device-clocked phases is enabled with `define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter logic [15:0] CMD_DEV        = 16'h0101,
  parameter int          INHIBIT_CYCLES = 5000,
  parameter int          TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output logic [2:0]    dbg_state
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    bitn, bitn_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic          err, err_n;
  logic          done_pend, done_pend_n;
  logic          clk_oe_n, data_oe_n;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          clk_s, data_s;
  logic          dev_hit, dev_hit_q, launch;
  logic          unused_data;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign dev_hit = (bus.DEVICE == CMD_DEV);
  assign launch  = dev_hit & ~dev_hit_q;
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  assign bus.status  = {13'b0, err, done, busy};
  assign dbg_state   = state;
  assign unused_data = ^bus.DATA[15:8];

  // Lines idle high, so synchronizers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      fall      <= 1'b0;
      dev_hit_q <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      fall      <= clk_sync[2] & ~clk_sync[1];
      dev_hit_q <= dev_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bitn        <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      done_pend   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bitn        <= bitn_n;
      shreg       <= shreg_n;
      par         <= par_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      done_pend   <= done_pend_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bitn_n      = bitn;
    shreg_n     = shreg;
    par_n       = par;
    busy_n      = busy;
    done_n      = done;
    err_n       = err;
    done_pend_n = 1'b0;
    clk_oe_n    = ps2_clk_oe;
    data_oe_n   = ps2_data_oe;

    // done trails busy by one cycle so a poller never sees busy and done together.
    if (done_pend) done_n = 1'b1;

    unique case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (launch) begin
          shreg_n  = bus.DATA[7:0];
          par_n    = ~^bus.DATA[7:0];
          done_n   = 1'b0;
          err_n    = 1'b0;
          busy_n   = 1'b1;
          cnt_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_n = 1'b1;
        cnt_n    = cnt_inc;
        if (cnt == INH_PRE) data_oe_n = 1'b1;
        if (cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          clk_oe_n  = 1'b0;
          cnt_n     = '0;
          state_n   = REQ;
        end
      end

      REQ: begin
        bitn_n  = '0;
        state_n = SHIFT;
      end

      SHIFT: begin
        if (fall) begin
          bitn_n = 4'(bitn + 4'd1);
          if (bitn < 4'd8) begin
            data_oe_n = ~shreg[bitn[2:0]];
          end else if (bitn == 4'd8) begin
            data_oe_n = ~par;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end
      end

      ACK: begin
        if (fall) begin
          err_n   = data_s;
          state_n = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_s && data_s) state_n = DONE;
      end

      DONE: begin
        busy_n      = 1'b0;
        done_pend_n = ~err;
        state_n     = IDLE;
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state == REQ || state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      cnt_n = cnt_inc;
      if (cnt == TO_LAST) begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        err_n     = 1'b1;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    end
`endif
  end

endmodule
